// File: rtl/forwarding_scoreboard.sv
// Operand-fetch scoreboard for the SimpleRISC pipeline: tracks in-flight
// destinations, chooses forwarding sources for both operands and raises load-use stalls.
module forwarding_scoreboard #(
   parameter int DEPTH    = 3,
   parameter int REG_W    = 4,
   parameter int RA_INDEX = 15,
   parameter int SEL_W    = $clog2(DEPTH + 1),
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             of_valid,
   input  logic [31:0]      of_instruction,
   input  logic             flush,
   output logic [SEL_W-1:0] fwd_sel_op1,
   output logic [SEL_W-1:0] fwd_sel_op2,
   output logic             stall,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [4:0] {
      OP_ADD  = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,  OP_DIV  = 5'd3,
      OP_MOD  = 5'd4,  OP_CMP = 5'd5,  OP_AND = 5'd6,  OP_OR   = 5'd7,
      OP_NOT  = 5'd8,  OP_MOV = 5'd9,  OP_LSL = 5'd10, OP_LSR  = 5'd11,
      OP_ASR  = 5'd12, OP_NOP = 5'd13, OP_LD  = 5'd14, OP_ST   = 5'd15,
      OP_BEQ  = 5'd16, OP_BGT = 5'd17, OP_B   = 5'd18, OP_CALL = 5'd19,
      OP_RET  = 5'd20
   } opcode_e;

   localparam logic [REG_W-1:0] RA = REG_W'(RA_INDEX);

   logic             validQ   [DEPTH];
   logic [REG_W-1:0] destQ    [DEPTH];
   logic             isLoadQ  [DEPTH];
   logic [CNT_W-1:0] stallCountQ, stallCountD;

   opcode_e          op;
   logic             immBit;
   logic             hasSrc1, hasSrc2, hasDest, isLoad;
   logic [REG_W-1:0] src1, src2, dest;
   logic             stage1LoadValid;

   always_comb begin
      op      = opcode_e'(of_instruction[31:27]);
      immBit  = of_instruction[26];
      hasSrc1 = 1'b0;
      hasSrc2 = 1'b0;
      hasDest = 1'b0;
      src1    = of_instruction[21:18];
      src2    = of_instruction[17:14];
      dest    = of_instruction[25:22];
      isLoad  = (op == OP_LD);

      if ((op <= OP_ASR && op != OP_NOT && op != OP_MOV) || op == OP_LD || op == OP_ST)
         hasSrc1 = 1'b1;
      else if (op == OP_RET) begin
         hasSrc1 = 1'b1;
         src1    = RA;
      end

      // Stores read the data register through the second port regardless of I.
      if (op <= OP_ASR && !immBit)
         hasSrc2 = 1'b1;
      else if (op == OP_ST) begin
         hasSrc2 = 1'b1;
         src2    = of_instruction[25:22];
      end

      if ((op <= OP_ASR && op != OP_CMP) || op == OP_LD)
         hasDest = 1'b1;
      else if (op == OP_CALL) begin
         hasDest = 1'b1;
         dest    = RA;
      end
   end

   // Scan oldest to youngest so the youngest matching stage is the last writer.
   always_comb begin
      fwd_sel_op1 = '0;
      fwd_sel_op2 = '0;
      if (of_valid) begin
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (validQ[k] && hasSrc1 && destQ[k] == src1)
               fwd_sel_op1 = SEL_W'(k + 1);
            if (validQ[k] && hasSrc2 && destQ[k] == src2)
               fwd_sel_op2 = SEL_W'(k + 1);
         end
      end
      stall = of_valid && !flush && isLoadQ[0] &&
              (fwd_sel_op1 == SEL_W'(1) || fwd_sel_op2 == SEL_W'(1));
      stage1LoadValid = of_valid && !flush && !stall;
      stallCountD = stallCountQ;
      if (stall && stallCountQ != '1)
         stallCountD = stallCountQ + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            validQ[k]  <= 1'b0;
            destQ[k]   <= '0;
            isLoadQ[k] <= 1'b0;
         end
         stallCountQ <= '0;
      end else begin
         validQ[0]  <= stage1LoadValid && hasDest;
         destQ[0]   <= dest;
         isLoadQ[0] <= stage1LoadValid && isLoad;
         for (int k = 1; k < DEPTH; k++) begin
            validQ[k]  <= validQ[k-1];
            destQ[k]   <= destQ[k-1];
            isLoadQ[k] <= isLoadQ[k-1];
         end
         stallCountQ <= stallCountD;
      end
   end

   assign stall_count = stallCountQ;

endmodule
